// File: rtl/crt_decrypt_ctrl_pkg.sv
// Shared types and constants for the RSA-CRT decryption sequencer.
package crt_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int EXP_CYCLES    = 2 * DEFAULT_WIDTH;

  typedef enum logic [3:0] {
    IDLE,
    INV,
    NORM,
    RED,
    EXP_P,
    EXP_Q,
    SUBH,
    MULH,
    RECOMB,
    DONE
  } crt_state_t;

endpackage

// File: rtl/crt_decrypt_ctrl_if.sv
// Request/result bundle between the key register file, the CRT sequencer and the output buffer.
interface crt_decrypt_ctrl_if
  import crt_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic                 start;
  logic [WIDTH-1:0]     p;
  logic [WIDTH-1:0]     q;
  logic [2*WIDTH-1:0]   c;
  logic [WIDTH-1:0]     d;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   m;
  logic [WIDTH-1:0]     qinv;
  logic                 err;

  modport master (
    output start, p, q, c, d,
    input  busy, done, m, qinv, err
  );

  modport slave (
    input  start, p, q, c, d,
    output busy, done, m, qinv, err
  );

endinterface

// File: rtl/crt_decrypt_ctrl_mod_mul.sv
// Combinational modular multiplier (a*b) mod n; a zero modulus yields 0.
module mod_mul
  import crt_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] r
);

  logic [2*WIDTH-1:0] prod;

  always_comb begin
    prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    r    = '0;
    if (n != '0) r = WIDTH'(prod % {{WIDTH{1'b0}}, n});
  end

endmodule

// File: rtl/crt_decrypt_ctrl.sv
// RSA-CRT decryption sequencer: Euclid inverse, exponent reduction, two constant-time exponentiations, Garner recombination.
// Optional parameter checking (gcd/p/q sanity, err flag) is enabled by defining CRT_PARAM_CHECK_EN.
module crt_decrypt_ctrl
  import crt_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  crt_decrypt_ctrl_if.slave bus
);

  localparam int            NCYC = 2 * WIDTH;
  localparam int            CW   = $clog2(NCYC);
  localparam logic [CW-1:0] LAST = CW'(NCYC - 1);

  crt_state_t             state;
  logic [WIDTH-1:0]       pr, qr, dr;
  logic [2*WIDTH-1:0]     cr;
  logic [WIDTH-1:0]       r0, r1;
  logic signed [WIDTH:0]  s0, s1;
  logic [CW-1:0]          cnt;
  logic [WIDTH-1:0]       e, acc, base;
  logic [WIDTH-1:0]       dq_r, cq_r;
  logic [WIDTH-1:0]       m1, m2, diff, h, qinv_r;
  logic                   busy_r, done_r;
  logic [2*WIDTH-1:0]     m_r;
  logic [WIDTH-1:0]       qinv_out;

  logic [WIDTH-1:0]       quo, rem, m2p;
  logic [WIDTH-1:0]       mul_a, mul_b, mul_n, mul_r;
  logic                   accept, euclid_exit;

`ifdef CRT_PARAM_CHECK_EN
  logic                   err_r;
  assign bus.err = err_r;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.m    = m_r;
  assign bus.qinv = qinv_out;

  assign accept      = bus.start && (state == IDLE || state == DONE);
  assign euclid_exit = (rem == '0) || (cnt == LAST);

  always_comb begin
    quo = '0;
    rem = '0;
    m2p = '0;
    if (r1 != '0) begin
      quo = r0 / r1;
      rem = r0 % r1;
    end
    if (pr != '0) m2p = m2 % pr;
  end

  // One multiplier: cycle A multiplies acc*base, cycle B squares base, MULH forms qinv*diff.
  always_comb begin
    mul_a = cnt[0] ? base : acc;
    mul_b = base;
    mul_n = (state == EXP_Q) ? qr : pr;
    if (state == MULH) begin
      mul_a = qinv_r;
      mul_b = diff;
    end
  end

  mod_mul #(.WIDTH(WIDTH)) u_mul (
    .a (mul_a),
    .b (mul_b),
    .n (mul_n),
    .r (mul_r)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pr       <= '0;
      qr       <= '0;
      dr       <= '0;
      cr       <= '0;
      r0       <= '0;
      r1       <= '0;
      s0       <= '0;
      s1       <= '0;
      cnt      <= '0;
      e        <= '0;
      acc      <= '0;
      base     <= '0;
      dq_r     <= '0;
      cq_r     <= '0;
      m1       <= '0;
      m2       <= '0;
      diff     <= '0;
      h        <= '0;
      qinv_r   <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      m_r      <= '0;
      qinv_out <= '0;
`ifdef CRT_PARAM_CHECK_EN
      err_r    <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      if (accept) begin
        pr     <= bus.p;
        qr     <= bus.q;
        cr     <= bus.c;
        dr     <= bus.d;
        r0     <= bus.p;
        r1     <= bus.q;
        s0     <= '0;
        s1     <= (WIDTH+1)'(1);
        cnt    <= '0;
        busy_r <= 1'b1;
        state  <= INV;
`ifdef CRT_PARAM_CHECK_EN
        err_r  <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: ;
          INV: begin
            if (euclid_exit) begin
`ifdef CRT_PARAM_CHECK_EN
              if (r1 != WIDTH'(1) || pr < WIDTH'(3) || qr < WIDTH'(2)) begin
                m_r      <= '0;
                qinv_out <= '0;
                err_r    <= 1'b1;
                busy_r   <= 1'b0;
                done_r   <= 1'b1;
                state    <= DONE;
              end else begin
                state <= NORM;
              end
`else
              state <= NORM;
`endif
            end else begin
              r0  <= r1;
              r1  <= rem;
              s0  <= s1;
              s1  <= s0 - $signed({1'b0, quo}) * s1;
              cnt <= cnt + 1'b1;
            end
          end
          NORM: begin
            qinv_r <= s1[WIDTH] ? WIDTH'(s1 + $signed({1'b0, pr})) : s1[WIDTH-1:0];
            state  <= RED;
          end
          // Reduce exponents and ciphertext, and seed the p-side exponentiation.
          RED: begin
            e     <= (pr > WIDTH'(1)) ? dr % (pr - 1'b1) : '0;
            dq_r  <= (qr > WIDTH'(1)) ? dr % (qr - 1'b1) : '0;
            base  <= (pr != '0) ? WIDTH'(cr % {{WIDTH{1'b0}}, pr}) : '0;
            cq_r  <= (qr != '0) ? WIDTH'(cr % {{WIDTH{1'b0}}, qr}) : '0;
            acc   <= {{(WIDTH-1){1'b0}}, pr != WIDTH'(1)};
            cnt   <= '0;
            state <= EXP_P;
          end
          EXP_P, EXP_Q: begin
            if (!cnt[0]) begin
              if (e[0]) acc <= mul_r;
            end else begin
              base <= mul_r;
              e    <= e >> 1;
            end
            if (cnt == LAST) begin
              cnt <= '0;
              if (state == EXP_P) begin
                m1    <= acc;
                acc   <= {{(WIDTH-1){1'b0}}, qr != WIDTH'(1)};
                base  <= cq_r;
                e     <= dq_r;
                state <= EXP_Q;
              end else begin
                m2    <= acc;
                state <= SUBH;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          SUBH: begin
            diff  <= (m1 >= m2p) ? m1 - m2p : m1 + pr - m2p;
            state <= MULH;
          end
          MULH: begin
            h     <= mul_r;
            state <= RECOMB;
          end
          RECOMB: begin
            m_r      <= (2*WIDTH)'(m2) + (2*WIDTH)'(h) * (2*WIDTH)'(qr);
            qinv_out <= qinv_r;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            state    <= DONE;
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_crt_decrypt_ctrl.sv
// Self-checking bench for crt_decrypt_ctrl: directed RSA-CRT cases plus random primes against a c^d mod pq model.
module tb_crt_decrypt_ctrl;
  import crt_pkg::*;

  localparam int W = DEFAULT_WIDTH;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  crt_decrypt_ctrl_if #(.WIDTH(W)) bus ();

  crt_decrypt_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] modPow(input logic [63:0] b, input logic [63:0] ex, input logic [63:0] n);
    logic [127:0] r;
    logic [127:0] x;
    logic [63:0]  k;
    k = ex;
    r = (n == 64'd1) ? 128'd0 : 128'd1;
    x = {64'd0, b % n};
    while (k != 64'd0) begin
      if (k[0]) r = (r * x) % {64'd0, n};
      x = (x * x) % {64'd0, n};
      k = k >> 1;
    end
    return r[63:0];
  endfunction

  function automatic int euclidSteps(input logic [63:0] a0, input logic [63:0] b0);
    logic [63:0] a, b, t;
    int k;
    a = a0;
    b = b0;
    k = 1;
    while (a % b != 64'd0) begin
      t = a % b;
      a = b;
      b = t;
      k++;
    end
    return k;
  endfunction

  function automatic bit isPrime(input logic [31:0] x);
    longint xv;
    xv = longint'(x);
    if (xv < 2) return 1'b0;
    for (longint i = 2; i * i <= xv; i++)
      if (xv % i == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] randPrime(input int unsigned hi);
    logic [31:0] x;
    do x = $urandom_range(hi, 3); while (!isPrime(x));
    return x;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] tp, input logic [W-1:0] tq,
                               input logic [2*W-1:0] tc, input logic [W-1:0] td,
                               input int glitchAt, output int lat);
    @(posedge clk); #1;
    bus.p     = tp;
    bus.q     = tq;
    bus.c     = tc;
    bus.d     = td;
    bus.start = 1'b1;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 4000) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        bus.start = 1'b0;
        checkOutput("busy_rise", 64'(bus.busy), 64'd1);
      end
      if (lat == glitchAt) begin
        bus.start = 1'b1;
        bus.c     = tc ^ 64'h5;
        bus.d     = td + 1'b1;
      end
      if (lat == glitchAt + 1) bus.start = 1'b0;
    end
    checkOutput("done_seen", 64'(bus.done), 64'd1);
  endtask

  task automatic runCase(input logic [W-1:0] tp, input logic [W-1:0] tq,
                         input logic [2*W-1:0] tc, input logic [W-1:0] td, input int glitchAt);
    logic [63:0] expM, expQinv;
    int lat, expLat;
    expM    = modPow(tc, {32'd0, td}, 64'(tp) * 64'(tq));
    expQinv = modPow({32'd0, tq}, {32'd0, tp} - 64'd2, {32'd0, tp});
    expLat  = euclidSteps({32'd0, tp}, {32'd0, tq}) + 2 * EXP_CYCLES + 6;
    applyStimulus(tp, tq, tc, td, glitchAt, lat);
    checkOutput("latency", 64'(lat), 64'(expLat));
    checkOutput("m", bus.m, expM);
    checkOutput("qinv", 64'(bus.qinv), expQinv);
    checkOutput("err", 64'(bus.err), 64'd0);
    checkOutput("busy_fall", 64'(bus.busy), 64'd0);
    @(posedge clk); #1;
    checkOutput("done_pulse", 64'(bus.done), 64'd0);
    checkOutput("m_hold", bus.m, expM);
  endtask

  initial begin
    logic [W-1:0]   rp, rq, rd;
    logic [2*W-1:0] rn, rc;
    int lat, doneSeen;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.p     = '0;
    bus.q     = '0;
    bus.c     = '0;
    bus.d     = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", 64'(bus.busy), 64'd0);
    checkOutput("rst_done", 64'(bus.done), 64'd0);
    checkOutput("rst_m", bus.m, 64'd0);
    checkOutput("rst_qinv", 64'(bus.qinv), 64'd0);
    checkOutput("rst_err", 64'(bus.err), 64'd0);
    rst = 1'b0;

    $display("[TB] directed cases");
    runCase(32'd61, 32'd53, 64'd2790, 32'd2753, 0);
    checkOutput("case1_m", bus.m, 64'd65);
    checkOutput("case1_qinv", 64'(bus.qinv), 64'd38);
    runCase(32'd3, 32'd11, 64'd8, 32'd7, 0);
    checkOutput("case2_m", bus.m, 64'd2);
    checkOutput("case2_qinv", 64'(bus.qinv), 64'd2);
    runCase(32'd61, 32'd53, 64'd0, 32'd2753, 0);
    runCase(32'd61, 32'd53, 64'd2790, 32'd60, 0);
    runCase(32'd61, 32'd53, 64'd2790, 32'd2753, 10);

    $display("[TB] reset during EXP_P");
    @(posedge clk); #1;
    bus.p = 32'd61; bus.q = 32'd53; bus.c = 64'd2790; bus.d = 32'd2753;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("abort_busy", 64'(bus.busy), 64'd0);
    checkOutput("abort_done", 64'(bus.done), 64'd0);
    checkOutput("abort_m", bus.m, 64'd0);
    checkOutput("abort_qinv", 64'(bus.qinv), 64'd0);
    checkOutput("abort_err", 64'(bus.err), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    doneSeen = 0;
    repeat (200) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) doneSeen++;
    end
    checkOutput("abort_quiet", 64'(doneSeen), 64'd0);
    runCase(32'd61, 32'd53, 64'd2790, 32'd2753, 0);

    $display("[TB] parameter check");
    applyStimulus(32'd6, 32'd4, 64'd5, 32'd7, 0, lat);
`ifdef CRT_PARAM_CHECK_EN
    checkOutput("perr_err", 64'(bus.err), 64'd1);
    checkOutput("perr_m", bus.m, 64'd0);
    checkOutput("perr_qinv", 64'(bus.qinv), 64'd0);
    checkOutput("perr_latency", 64'(lat), 64'(euclidSteps(64'd6, 64'd4) + 1));
`else
    checkOutput("perr_err_off", 64'(bus.err), 64'd0);
`endif
    @(posedge clk); #1;
    checkOutput("perr_done_pulse", 64'(bus.done), 64'd0);
    runCase(32'd3, 32'd11, 64'd8, 32'd7, 0);

    $display("[TB] random primes");
    for (int i = 0; i < 8; i++) begin
      rp = randPrime((i < 4) ? 32'd65535 : 32'h7FFF_FFFF);
      do rq = randPrime((i < 4) ? 32'd65535 : 32'h7FFF_FFFF); while (rq == rp);
      rn = 64'(rp) * 64'(rq);
      do rc = {$urandom, $urandom} % rn; while (rc % 64'(rp) == 0 || rc % 64'(rq) == 0);
      rd = $urandom;
      runCase(rp, rq, rc, rd, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/crt_decrypt_ctrl.md
Name: crt_decrypt_ctrl

Overview:
- Sequencer for RSA-CRT decryption.
- Latches p, q, c and d on start, then runs in order: extended Euclid (qinv = q^-1 mod p), exponent reduction, two constant-time modular exponentiations on one shared modular multiplier, and Garner recombination.
- Presents m with a start/busy/done handshake. Sits between the key/ciphertext register file and the output buffer.

Parameters:
- WIDTH, 32, width of the primes p, q and of the exponent d; c and m are 2*WIDTH.

Ports:
- clk    in   1          rising-edge clock
- rst    in   1          asynchronous, active-high reset
- start  in   1          request; sampled only in IDLE or DONE
- p      in   WIDTH      prime p (>=3); the qinv modulus
- q      in   WIDTH      prime q (>=2)
- c      in   2*WIDTH    ciphertext, < p*q
- d      in   WIDTH      private exponent
- busy   out  1          high from the cycle after start is accepted until DONE
- done   out  1          one-cycle pulse on entry to DONE
- m      out  2*WIDTH    plaintext; valid while done is high, held until the next start
- qinv   out  WIDTH      q^-1 mod p in [0,p-1]; same validity as m
- err    out  1          parameter error flag (see Optional Feature); tied 0 without the macro

Behaviour:
- Reset: all outputs 0, state IDLE, internal registers 0. Reset mid-operation aborts immediately; no done pulse.
- Start acceptance:
  - In IDLE or DONE with start=1: latch p, q, c, d; go to INV next cycle.
  - start while busy is ignored.
  - In DONE with start=0: return to IDLE; m and qinv keep their values.
- FSM: IDLE -> INV -> NORM -> RED -> EXP_P -> EXP_Q -> SUBH -> MULH -> RECOMB -> DONE.
- INV (Euclid):
  - Init r0=p, r1=q, s0=0, s1=1; signed WIDTH+1 coefficients.
  - Each cycle: quotient=r0/r1; (r0,r1)<=(r1, r0 mod r1); (s0,s1)<=(s1, s0-quotient*s1).
  - Leave when the next remainder is 0, i.e. when r0 mod r1 == 0; s1 then holds the coefficient.
  - k iterations; k is bounded by 2*WIDTH.
- NORM (1 cycle): qinv_r = s1 if s1 >= 0, else s1+p.
- RED (1 cycle): dp=d mod (p-1), dq=d mod (q-1), cp=c mod p, cq=c mod q.
- EXP_P / EXP_Q:
  - Right-to-left square-and-multiply over all WIDTH exponent bits, LSB first. Exponent bits are dp for EXP_P and dq for EXP_Q.
  - Constant time: 2 cycles per bit.
    - Cycle A: acc <= bit ? acc*base mod n : acc.
    - Cycle B: base <= base*base mod n.
  - acc initialised to 1 mod n. Exactly 2*WIDTH cycles per phase.
  - Results: m1 from EXP_P, m2 from EXP_Q.
- SUBH (1 cycle): diff = m1 - (m2 mod p); add p if negative. Result in [0,p-1].
- MULH (1 cycle): h = qinv_r*diff mod p, using the shared multiplier.
- RECOMB (1 cycle): m <= m2 + h*q (2*WIDTH, no overflow since < p*q); qinv <= qinv_r.
- Latency: start accepted -> done = k + 4*WIDTH + 6 cycles. With the fixed-latency phases in order: INV k, NORM 1, RED 1, EXP_P 2*WIDTH, EXP_Q 2*WIDTH, SUBH 1, MULH 1, RECOMB 1, then done.
- Shared multiplier:
  - Exactly one modular multiply per cycle.
  - Operands and modulus are selected by state; the result is registered by the controller.
- Edge cases:
  - dp=0 or dq=0 gives m1=1 mod p (resp. m2=1 mod q).
  - c=0 gives m=0.
  - p<q and q<p must both be handled.

Optional Feature:
- Macro: CRT_PARAM_CHECK_EN.
- With the macro defined:
  - On INV exit, if the final nonzero remainder is not 1 (gcd(p,q) != 1), or p<3, or q<2, go directly to DONE.
  - In that case err=1, m=0, qinv=0, and done pulses.
  - err clears on the next accepted start.
- Without the macro: no checks are made, err is constant 0, and results for invalid inputs are undefined but the FSM still terminates.

Decomposition:
- Package crt_pkg holds:
  - state enum crt_state_t with encodings IDLE..DONE;
  - WIDTH default;
  - helper constant EXP_CYCLES = 2*WIDTH.
- Sub-module mod_mul: combinational (a*b) mod n.
  - a, b and n are WIDTH bits; 2*WIDTH product; WIDTH result.
  - Single instance, muxed by the controller.

Test Plan:
- p=61, q=53, d=2753, c=2790 -> qinv=38, m=65, one done pulse exactly k+4*WIDTH+6 cycles after start. This case also covers m1=4 < m2=12.
- p=3, q=11, d=7, c=8 -> qinv=2, m=2. This covers p<q.
- Same as case 1 with c=0 -> m=0; with d=60 -> dp=0 path exercised, m matches the golden model.
- start pulsed again 10 cycles into an operation -> ignored; result and done timing unchanged. Assert rst mid-EXP_P -> outputs 0, IDLE, no done; a new start afterwards gives a correct m.
- With CRT_PARAM_CHECK_EN: p=6, q=4 -> err=1, m=0, qinv=0, done pulses. A subsequent valid start clears err. Without the macro, err stays 0 throughout.
- Randomised primes below 2^16 and below 2^31, checked against a c^d mod pq reference model; done latency matches the formula for every run.
